// File: rtl/lsu.sv
// Load/store unit: aligned loads with sign/zero extension, single-cycle word stores,
// and two-cycle read-modify-write for byte/half stores against a single-port data memory.
module lsu #(
    parameter int DM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_sign,
    input  logic [DM_AW+1:0]  i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [31:0]       i_req_pc,
    output logic              o_stall,
    output logic              o_dm_we,
    output logic [DM_AW-1:0]  o_dm_addr,
    output logic [31:0]       o_dm_din,
    output logic [31:0]       o_dm_pc,
    input  logic [31:0]       i_dm_dout,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_valid,
    output logic              o_misalign
);

    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t             r_state;
    logic [31:0]        r_merge;
    logic [31:0]        r_pc;
    logic [DM_AW-1:0]   r_addr;
    logic [31:0]        r_rdata;
    logic               r_rdata_valid;
    logic               r_misalign;

    logic [1:0]         w_off;
    logic               w_idle;
    logic               w_bad;
    logic               w_go;
    logic               w_ld;
    logic               w_sw;
    logic               w_rmw;
    logic [31:0]        w_shift;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ext;
    logic [3:0]         w_lane_en;
    logic [31:0]        w_merged;

    assign w_off  = i_req_addr[1:0];
    assign w_idle = (r_state == IDLE);
    assign w_bad  = (i_req_size == 2'b11)
                  | ((i_req_size == 2'b01) & w_off[0])
                  | ((i_req_size == 2'b10) & (w_off != 2'b00));
    assign w_go   = w_idle & i_req_valid & ~w_bad;
    assign w_ld   = w_go & ~i_req_we;
    assign w_sw   = w_go & i_req_we & (i_req_size == 2'b10);
    assign w_rmw  = w_go & i_req_we & (i_req_size != 2'b10);

    // Little-endian lane select: offset 0 is bits 7:0
    assign w_shift = i_dm_dout >> {w_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_off[1] ? i_dm_dout[31:16] : i_dm_dout[15:0];

    always_comb begin
        case (i_req_size)
            2'b00:   w_ext = {{24{i_req_sign & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{i_req_sign & w_half[15]}}, w_half};
            default: w_ext = i_dm_dout;
        endcase
    end

    always_comb begin
        if (i_req_size == 2'b00)
            w_lane_en = 4'b0001 << w_off;
        else
            w_lane_en = w_off[1] ? 4'b1100 : 4'b0011;
    end

    // Untouched lanes pass the current memory word through unchanged
    always_comb begin
        w_merged = i_dm_dout;
        for (int i = 0; i < 4; i++) begin
            if (w_lane_en[i]) begin
                if (i_req_size == 2'b00 || (i % 2) == 0)
                    w_merged[8*i +: 8] = i_req_wdata[7:0];
                else
                    w_merged[8*i +: 8] = i_req_wdata[15:8];
            end
        end
    end

    // Gating with reset makes the write port drop the instant reset asserts
    assign o_stall       = i_rst_n & w_rmw;
    assign o_dm_we       = i_rst_n & (w_sw | (r_state == RMW_WR));
    assign o_dm_addr     = w_idle ? i_req_addr[DM_AW+1:2] : r_addr;
    assign o_dm_din      = w_idle ? i_req_wdata : r_merge;
    assign o_dm_pc       = w_idle ? i_req_pc : r_pc;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_misalign    = r_misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_merge       <= '0;
            r_pc          <= '0;
            r_addr        <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdata_valid <= w_ld;
                    r_misalign    <= i_req_valid & w_bad;
                    if (w_ld)
                        r_rdata <= w_ext;
                    if (w_rmw) begin
                        r_merge <= w_merged;
                        r_addr  <= i_req_addr[DM_AW+1:2];
                        r_pc    <= i_req_pc;
                        r_state <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    r_rdata_valid <= 1'b0;
                    r_misalign    <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed requests push expected writes/loads/rejections,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu;

    localparam int DM_AW = 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [DM_AW+1:0]  req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              stall;
    logic              dm_we;
    logic [DM_AW-1:0]  dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_pc;
    logic [31:0]       dm_dout;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              misalign;

    logic [31:0] mem [0:(1<<DM_AW)-1];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    int          mis_pend;
    int          n_cmp;
    int          n_bad;

    lsu #(.DM_AW(DM_AW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_we      (req_we),
        .i_req_size    (req_size),
        .i_req_sign    (req_sign),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_pc      (req_pc),
        .o_stall       (stall),
        .o_dm_we       (dm_we),
        .o_dm_addr     (dm_addr),
        .o_dm_din      (dm_din),
        .o_dm_pc       (dm_pc),
        .i_dm_dout     (dm_dout),
        .o_rdata       (rdata),
        .o_rdata_valid (rdata_valid),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_we)
            mem[dm_addr] <= dm_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_dm_we_addr", {24'h0, dm_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", {24'h0, dm_addr}, e.addr);
                    chk("wr_din",  dm_din, e.data);
                    chk("wr_pc",   dm_pc, e.pc);
                end
            end
            if (rdata_valid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rdata_valid", rdata, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] r;
                    r = rd_q.pop_front();
                    chk("load_rdata", rdata, r);
                end
            end
            if (misalign) begin
                chk("misalign_expected", 32'(mis_pend > 0), 32'd1);
                if (mis_pend > 0) mis_pend--;
            end
            if (rdata_valid && misalign)
                chk("valid_and_misalign_exclusive", 32'd1, 32'd0);
        end
    end

    // Issue one request and count cycles until the upstream is released
    task automatic issue(input string name, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [9:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input int exp_cyc);
        int  cyc;
        logic s;
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = a;
        req_wdata = wd;
        req_pc    = pc;
        cyc = 0;
        s   = 1'b1;
        while (s && cyc < 4) begin
            @(negedge clk);
            s = stall;
            @(posedge clk);
            cyc++;
        end
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic bubble();
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_dm_we", 32'(dm_we), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_misalign", 32'(misalign), 32'd0);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; mis_pend = 0;
        for (int i = 0; i < (1<<DM_AW); i++) mem[i] = 32'h0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'h80FF_7F01;
        mem[3] = 32'hDEAD_BEEF;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_sign = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // Loads from word 0x80FF7F01 at 0x04
        rd_q.push_back(32'hFFFF_FF80); issue("lb_07",  0, 2'b00, 1, 10'h007, 0, 32'h100, 1);
        rd_q.push_back(32'h0000_0080); issue("lbu_07", 0, 2'b00, 0, 10'h007, 0, 32'h104, 1);
        rd_q.push_back(32'h0000_7F01); issue("lh_04",  0, 2'b01, 1, 10'h004, 0, 32'h108, 1);
        rd_q.push_back(32'hFFFF_80FF); issue("lh_06",  0, 2'b01, 1, 10'h006, 0, 32'h10C, 1);

        // sw then sb into the same word
        wr_q.push_back('{32'd1, 32'h1122_3344, 32'h110});
        issue("sw_04", 1, 2'b10, 0, 10'h004, 32'h1122_3344, 32'h110, 1);
        wr_q.push_back('{32'd1, 32'h1122_AB44, 32'h114});
        issue("sb_05", 1, 2'b00, 0, 10'h005, 32'h0000_00AB, 32'h114, 2);

        // sh then lw back-to-back
        wr_q.push_back('{32'd0, 32'hBEEF_3344, 32'h118});
        issue("sh_02", 1, 2'b01, 0, 10'h002, 32'h0000_BEEF, 32'h118, 2);
        rd_q.push_back(32'hBEEF_3344); issue("lw_00", 0, 2'b10, 0, 10'h000, 0, 32'h11C, 1);

        // Rejected requests, including a rejected store
        mis_pend++; issue("lh_01", 0, 2'b01, 1, 10'h001, 0, 32'h120, 1);
        mis_pend++; issue("lw_02", 0, 2'b10, 0, 10'h002, 0, 32'h124, 1);
        mis_pend++; issue("sz11_00", 1, 2'b11, 0, 10'h000, 32'h5555_5555, 32'h128, 1);
        bubble();
        chk("rdata_held_after_misalign", rdata, 32'hBEEF_3344);
        chk("misalign_all_seen", 32'(mis_pend), 32'd0);

        // sw, lw, sb, lw with no bubbles
        wr_q.push_back('{32'd2, 32'hCAFE_BABE, 32'h200});
        issue("seq_sw", 1, 2'b10, 0, 10'h008, 32'hCAFE_BABE, 32'h200, 1);
        rd_q.push_back(32'hCAFE_BABE); issue("seq_lw1", 0, 2'b10, 0, 10'h008, 0, 32'h204, 1);
        wr_q.push_back('{32'd2, 32'hCA55_BABE, 32'h208});
        issue("seq_sb", 1, 2'b00, 0, 10'h00A, 32'h0000_0055, 32'h208, 2);
        rd_q.push_back(32'hCA55_BABE); issue("seq_lw2", 0, 2'b10, 0, 10'h008, 0, 32'h20C, 1);
        bubble();

        // Reset during RMW_WR abandons the write
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 10'h00C; req_wdata = 32'h77; req_pc = 32'h300;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rmw_rst_dm_we", 32'(dm_we), 32'd0);
        chk("rmw_rst_stall", 32'(stall), 32'd0);
        chk("rmw_rst_rdata", rdata, 32'd0);
        chk("rmw_rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rmw_rst_misalign", 32'(misalign), 32'd0);
        repeat (2) @(posedge clk);
        chk("rmw_rst_mem_unchanged", mem[3], 32'hDEAD_BEEF);
        #1;
        rst_n = 1'b1;
        @(posedge clk);

        rd_q.push_back(32'h0000_00EF); issue("post_rst_lbu_0c", 0, 2'b00, 0, 10'h00C, 0, 32'h304, 1);
        bubble();
        repeat (3) @(posedge clk);

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
